// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32 subset control FSM
// State is registered; control outputs decode from state and are forced to 0 while reset is high.
module multicycle_control_unit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               PcWrite,
    output logic               PCSrc,
    output logic               IMemRead,
    output logic               IrWrite,
    output logic               DMemRead,
    output logic               DMemWrite,
    output logic               LoadMDR,
    output logic               WriteReg,
    output logic [1:0]         MemToReg,
    output logic               LoadRegA,
    output logic               LoadRegB,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [2:0]         SEFct,
    output logic [2:0]         AluFct,
    output logic               LoadAOut,
    output logic               illegal,
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] SEF_I = 3'b000;
    localparam logic [2:0] SEF_S = 3'b001;
    localparam logic [2:0] SEF_B = 3'b010;
    localparam logic [2:0] SEF_J = 3'b011;

    state_t     r_state;
    state_t     w_next;
    logic       w_imem_ok;
    logic       w_dmem_ok;
    logic       w_rtype;
    logic       w_func_ok;
    logic       w_br_ok;
    logic       w_store;
    logic [2:0] w_alu_fct;

    // Without handshaking every memory state completes in a single cycle.
    assign w_imem_ok = (MEM_HANDSHAKE == 0) || imem_ready;
    assign w_dmem_ok = (MEM_HANDSHAKE == 0) || dmem_ready;
    assign w_rtype   = (opcode == OP_R);
    assign w_store   = (opcode == OP_STORE);
    assign w_br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);

    always_comb begin
        w_alu_fct = ALU_ADD;
        w_func_ok = 1'b1;
        case (funct3)
            3'b000:  w_alu_fct = (w_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  w_alu_fct = ALU_AND;
            3'b110:  w_alu_fct = ALU_OR;
            3'b100:  w_alu_fct = ALU_XOR;
            3'b010:  w_alu_fct = ALU_SLT;
            3'b001:  w_alu_fct = ALU_SLL;
            3'b101: begin
                // Arithmetic right shift is not supported in either format.
                w_alu_fct = ALU_SRL;
                w_func_ok = !funct7_5;
            end
            default: w_func_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (w_imem_ok) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:              w_next = w_func_ok ? S_EXEC_R : S_TRAP;
                    OP_I:              w_next = w_func_ok ? S_EXEC_I : S_TRAP;
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_BRANCH:         w_next = w_br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:    w_next = S_ALU_WB;
            S_EXEC_I:    w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_MEM_ADDR:  w_next = w_store ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (w_dmem_ok) w_next = S_MEM_WB;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: if (w_dmem_ok) w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JAL:       w_next = S_FETCH;
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Masking with reset makes an in-flight access drop its strobes without waiting for an edge.
    always_comb begin
        PcWrite   = 1'b0;
        PCSrc     = 1'b0;
        IMemRead  = 1'b0;
        IrWrite   = 1'b0;
        DMemRead  = 1'b0;
        DMemWrite = 1'b0;
        LoadMDR   = 1'b0;
        WriteReg  = 1'b0;
        MemToReg  = 2'b00;
        LoadRegA  = 1'b0;
        LoadRegB  = 1'b0;
        AluSrcA   = 1'b0;
        AluSrcB   = 2'b00;
        SEFct     = SEF_I;
        AluFct    = ALU_ADD;
        LoadAOut  = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    IMemRead = 1'b1;
                    AluSrcB  = 2'b01;
                    IrWrite  = w_imem_ok;
                    PcWrite  = w_imem_ok;
                end
                S_DECODE: begin
                    LoadRegA = 1'b1;
                    LoadRegB = 1'b1;
                    LoadAOut = 1'b1;
                    AluSrcB  = 2'b10;
                    SEFct    = (opcode == OP_JAL) ? SEF_J : SEF_B;
                end
                S_EXEC_R: begin
                    AluSrcA  = 1'b1;
                    AluSrcB  = 2'b00;
                    AluFct   = w_alu_fct;
                    LoadAOut = 1'b1;
                end
                S_EXEC_I: begin
                    AluSrcA  = 1'b1;
                    AluSrcB  = 2'b10;
                    SEFct    = SEF_I;
                    AluFct   = w_alu_fct;
                    LoadAOut = 1'b1;
                end
                S_ALU_WB: begin
                    WriteReg = 1'b1;
                    MemToReg = 2'b00;
                end
                S_MEM_ADDR: begin
                    AluSrcA  = 1'b1;
                    AluSrcB  = 2'b10;
                    SEFct    = w_store ? SEF_S : SEF_I;
                    LoadAOut = 1'b1;
                end
                S_MEM_READ: begin
                    DMemRead = 1'b1;
                    LoadMDR  = w_dmem_ok;
                end
                S_MEM_WB: begin
                    WriteReg = 1'b1;
                    MemToReg = 2'b01;
                end
                S_MEM_WRITE: DMemWrite = 1'b1;
                S_BRANCH: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b00;
                    AluFct  = ALU_SUB;
                    PCSrc   = 1'b1;
                    PcWrite = funct3[0] ? !zero : zero;
                end
                S_JAL: begin
                    WriteReg = 1'b1;
                    MemToReg = 2'b10;
                    PcWrite  = 1'b1;
                    PCSrc    = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_out = '0;
        if (!reset) begin
            state_out[3:0] = r_state;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
// Instance a uses handshaking (STATE_W=4); instance b ignores ready (STATE_W=6).
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [5:0] st;
        logic       pcw;
        logic       pcsrc;
        logic       imr;
        logic       irw;
        logic       dmr;
        logic       dmw;
        logic       ldmdr;
        logic       wreg;
        logic [1:0] m2r;
        logic       lra;
        logic       lrb;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] sef;
        logic [2:0] alu;
        logic       lao;
        logic       ill;
    } ctrl_t;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;

    logic       a_PcWrite, a_PCSrc, a_IMemRead, a_IrWrite, a_DMemRead, a_DMemWrite, a_LoadMDR, a_WriteReg;
    logic [1:0] a_MemToReg, a_AluSrcB;
    logic       a_LoadRegA, a_LoadRegB, a_AluSrcA, a_LoadAOut, a_illegal;
    logic [2:0] a_SEFct, a_AluFct;
    logic [3:0] a_state_out;

    logic       b_PcWrite, b_PCSrc, b_IMemRead, b_IrWrite, b_DMemRead, b_DMemWrite, b_LoadMDR, b_WriteReg;
    logic [1:0] b_MemToReg, b_AluSrcB;
    logic       b_LoadRegA, b_LoadRegB, b_AluSrcA, b_LoadAOut, b_illegal;
    logic [2:0] b_SEFct, b_AluFct;
    logic [5:0] b_state_out;

    int vectors;
    int miscompares;

    ctrl_t      exp_q[$];
    logic [2:0] stim_q[$];

    multicycle_control_unit #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .PcWrite(a_PcWrite), .PCSrc(a_PCSrc), .IMemRead(a_IMemRead), .IrWrite(a_IrWrite),
        .DMemRead(a_DMemRead), .DMemWrite(a_DMemWrite), .LoadMDR(a_LoadMDR), .WriteReg(a_WriteReg),
        .MemToReg(a_MemToReg), .LoadRegA(a_LoadRegA), .LoadRegB(a_LoadRegB), .AluSrcA(a_AluSrcA),
        .AluSrcB(a_AluSrcB), .SEFct(a_SEFct), .AluFct(a_AluFct), .LoadAOut(a_LoadAOut),
        .illegal(a_illegal), .state_out(a_state_out)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(0), .STATE_W(6)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .PcWrite(b_PcWrite), .PCSrc(b_PCSrc), .IMemRead(b_IMemRead), .IrWrite(b_IrWrite),
        .DMemRead(b_DMemRead), .DMemWrite(b_DMemWrite), .LoadMDR(b_LoadMDR), .WriteReg(b_WriteReg),
        .MemToReg(b_MemToReg), .LoadRegA(b_LoadRegA), .LoadRegB(b_LoadRegB), .AluSrcA(b_AluSrcA),
        .AluSrcB(b_AluSrcB), .SEFct(b_SEFct), .AluFct(b_AluFct), .LoadAOut(b_LoadAOut),
        .illegal(b_illegal), .state_out(b_state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t obs_a();
        ctrl_t c;
        c = {2'b00, a_state_out, a_PcWrite, a_PCSrc, a_IMemRead, a_IrWrite, a_DMemRead, a_DMemWrite,
             a_LoadMDR, a_WriteReg, a_MemToReg, a_LoadRegA, a_LoadRegB, a_AluSrcA, a_AluSrcB,
             a_SEFct, a_AluFct, a_LoadAOut, a_illegal};
        return c;
    endfunction

    function automatic ctrl_t obs_b();
        ctrl_t c;
        c = {b_state_out, b_PcWrite, b_PCSrc, b_IMemRead, b_IrWrite, b_DMemRead, b_DMemWrite,
             b_LoadMDR, b_WriteReg, b_MemToReg, b_LoadRegA, b_LoadRegB, b_AluSrcA, b_AluSrcB,
             b_SEFct, b_AluFct, b_LoadAOut, b_illegal};
        return c;
    endfunction

    // Expected control words per state, written from the state table.
    function automatic ctrl_t c0(input int code);
        ctrl_t c;
        c    = '0;
        c.st = 6'(code);
        return c;
    endfunction

    function automatic ctrl_t f_fetch(input logic rdy);
        ctrl_t c;
        c = c0(0); c.imr = 1'b1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy;
        return c;
    endfunction

    function automatic ctrl_t f_decode(input logic j);
        ctrl_t c;
        c = c0(1); c.lra = 1'b1; c.lrb = 1'b1; c.lao = 1'b1; c.asb = 2'b10;
        c.sef = j ? 3'b011 : 3'b010;
        return c;
    endfunction

    function automatic ctrl_t f_exec_r(input logic [2:0] alu);
        ctrl_t c;
        c = c0(2); c.asa = 1'b1; c.asb = 2'b00; c.alu = alu; c.lao = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_exec_i(input logic [2:0] alu);
        ctrl_t c;
        c = c0(3); c.asa = 1'b1; c.asb = 2'b10; c.sef = 3'b000; c.alu = alu; c.lao = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_alu_wb();
        ctrl_t c;
        c = c0(4); c.wreg = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_mem_addr(input logic store);
        ctrl_t c;
        c = c0(5); c.asa = 1'b1; c.asb = 2'b10; c.sef = store ? 3'b001 : 3'b000; c.lao = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_mem_read(input logic rdy);
        ctrl_t c;
        c = c0(6); c.dmr = 1'b1; c.ldmdr = rdy;
        return c;
    endfunction

    function automatic ctrl_t f_mem_wb();
        ctrl_t c;
        c = c0(7); c.wreg = 1'b1; c.m2r = 2'b01;
        return c;
    endfunction

    function automatic ctrl_t f_mem_write();
        ctrl_t c;
        c = c0(8); c.dmw = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_branch(input logic pcw);
        ctrl_t c;
        c = c0(9); c.asa = 1'b1; c.asb = 2'b00; c.alu = 3'b001; c.pcsrc = 1'b1; c.pcw = pcw;
        return c;
    endfunction

    function automatic ctrl_t f_jal();
        ctrl_t c;
        c = c0(10); c.wreg = 1'b1; c.m2r = 2'b10; c.pcw = 1'b1; c.pcsrc = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t f_trap();
        ctrl_t c;
        c = c0(15); c.ill = 1'b1;
        return c;
    endfunction

    task automatic push(input logic im, input logic dm, input logic z, input ctrl_t e);
        stim_q.push_back({im, dm, z});
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic test_reset();
        ctrl_t g;
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1;
        set_ir(7'b0110011, 3'b000, 1'b0);
        @(negedge clk);
        g = obs_a(); vectors++;
        if (g !== ctrl_t'(0)) begin miscompares++; $display("FAIL reset_a: got %h expected %h", g, ctrl_t'(0)); end
        g = obs_b(); vectors++;
        if (g !== ctrl_t'(0)) begin miscompares++; $display("FAIL reset_b: got %h expected %h", g, ctrl_t'(0)); end
        @(posedge clk); #1;
        reset = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        g = obs_a(); vectors++;
        if (g !== f_fetch(1'b0)) begin miscompares++; $display("FAIL release_a: got %h expected %h", g, f_fetch(1'b0)); end
        g = obs_b(); vectors++;
        if (g !== f_fetch(1'b1)) begin miscompares++; $display("FAIL release_b: got %h expected %h", g, f_fetch(1'b1)); end
    endtask

    task automatic test_add_nohs();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b0110011, 3'b000, 1'b0);
        push(0, 0, 0, f_fetch(1'b1));
        push(0, 0, 0, f_decode(1'b0));
        push(0, 0, 0, f_exec_r(3'b000));
        push(0, 0, 0, f_alu_wb());
        push(0, 0, 0, f_fetch(1'b1));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_b(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL add_nohs: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_wait();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b0110011, 3'b000, 1'b1);
        push(0, 0, 0, f_fetch(1'b0));
        push(0, 0, 0, f_fetch(1'b0));
        push(1, 0, 0, f_fetch(1'b1));
        push(1, 0, 0, f_decode(1'b0));
        push(1, 0, 0, f_exec_r(3'b001));
        push(1, 0, 0, f_alu_wb());
        push(0, 0, 0, f_fetch(1'b0));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_a(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL sub_wait: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_itype();
        ctrl_t e, g;
        logic [2:0] s;
        logic [2:0] f3s [3] = '{3'b101, 3'b000, 3'b010};
        logic       f7s [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0] alus[3] = '{3'b111, 3'b000, 3'b101};
        for (int i = 0; i < 3; i++) begin
            apply_reset();
            set_ir(7'b0010011, f3s[i], f7s[i]);
            push(1, 0, 0, f_fetch(1'b1));
            push(1, 0, 0, f_decode(1'b0));
            push(1, 0, 0, f_exec_i(alus[i]));
            push(1, 0, 0, f_alu_wb());
            while (exp_q.size() > 0) begin
                s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
                @(negedge clk);
                e = exp_q.pop_front(); g = obs_a(); vectors++;
                if (g !== e) begin miscompares++; $display("FAIL itype_%0d: got %h expected %h", i, g, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_wait();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b0000011, 3'b010, 1'b0);
        push(1, 0, 0, f_fetch(1'b1));
        push(1, 0, 0, f_decode(1'b0));
        push(1, 0, 0, f_mem_addr(1'b0));
        push(1, 0, 0, f_mem_read(1'b0));
        push(1, 0, 0, f_mem_read(1'b0));
        push(1, 0, 0, f_mem_read(1'b0));
        push(1, 1, 0, f_mem_read(1'b1));
        push(1, 0, 0, f_mem_wb());
        push(1, 0, 0, f_fetch(1'b1));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_a(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL load_wait: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b0100011, 3'b010, 1'b0);
        push(1, 0, 0, f_fetch(1'b1));
        push(1, 0, 0, f_decode(1'b0));
        push(1, 0, 0, f_mem_addr(1'b1));
        push(1, 0, 0, f_mem_write());
        push(1, 1, 0, f_mem_write());
        push(1, 0, 0, f_fetch(1'b1));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_a(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL store: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        ctrl_t e, g;
        logic [2:0] s;
        logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       pcws[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            apply_reset();
            set_ir(7'b1100011, f3s[i], 1'b0);
            push(1, 0, !zs[i], f_fetch(1'b1));
            push(1, 0, !zs[i], f_decode(1'b0));
            push(1, 0, zs[i], f_branch(pcws[i]));
            push(1, 0, 0, f_fetch(1'b1));
            while (exp_q.size() > 0) begin
                s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
                @(negedge clk);
                e = exp_q.pop_front(); g = obs_a(); vectors++;
                if (g !== e) begin miscompares++; $display("FAIL branch_%0d: got %h expected %h", i, g, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jal();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b1101111, 3'b000, 1'b0);
        push(1, 0, 0, f_fetch(1'b1));
        push(1, 0, 0, f_decode(1'b1));
        push(1, 0, 0, f_jal());
        push(1, 0, 0, f_fetch(1'b1));
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_a(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL jal: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b1111111, 3'b000, 1'b0);
        push(1, 0, 0, f_fetch(1'b1));
        push(1, 0, 0, f_decode(1'b0));
        for (int i = 0; i < 10; i++) begin
            push(i[0], i[1], i[0] ^ i[1], f_trap());
        end
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_a(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL trap_hold: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        g = obs_a(); vectors++;
        if (g !== ctrl_t'(0)) begin miscompares++; $display("FAIL trap_reset: got %h expected %h", g, ctrl_t'(0)); end
        @(posedge clk); #1;
        reset = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        g = obs_a(); vectors++;
        if (g !== f_fetch(1'b0)) begin miscompares++; $display("FAIL trap_release: got %h expected %h", g, f_fetch(1'b0)); end
    endtask

    task automatic test_illegal_decode();
        ctrl_t e, g;
        logic [2:0] s;
        logic [6:0] ops[4] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110011};
        logic [2:0] f3s[4] = '{3'b011, 3'b101, 3'b100, 3'b101};
        logic       f7s[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply_reset();
            set_ir(ops[i], f3s[i], f7s[i]);
            push(1, 0, 0, f_fetch(1'b1));
            push(1, 0, 0, f_decode(1'b0));
            push(1, 1, 1, f_trap());
            push(1, 1, 0, f_trap());
            while (exp_q.size() > 0) begin
                s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
                @(negedge clk);
                e = exp_q.pop_front(); g = obs_a(); vectors++;
                if (g !== e) begin miscompares++; $display("FAIL bad_func_%0d: got %h expected %h", i, g, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        ctrl_t e, g;
        logic [2:0] s;
        apply_reset();
        set_ir(7'b0100011, 3'b000, 1'b0);
        push(1, 0, 0, f_fetch(1'b1));
        push(1, 0, 0, f_decode(1'b0));
        push(1, 0, 0, f_mem_addr(1'b1));
        push(1, 0, 0, f_mem_write());
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); {imem_ready, dmem_ready, zero} = s;
            @(negedge clk);
            e = exp_q.pop_front(); g = obs_a(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL mid_write_seq: got %h expected %h", g, e); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        g = obs_a(); vectors++;
        if (g !== f_mem_write()) begin miscompares++; $display("FAIL mid_write_hold: got %h expected %h", g, f_mem_write()); end
        #2 reset = 1'b1;
        #1;
        g = obs_a(); vectors++;
        if (g !== ctrl_t'(0)) begin miscompares++; $display("FAIL mid_write_abort: got %h expected %h", g, ctrl_t'(0)); end
        @(posedge clk); #1;
        reset = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        g = obs_a(); vectors++;
        if (g !== f_fetch(1'b0)) begin miscompares++; $display("FAIL mid_write_resume: got %h expected %h", g, f_fetch(1'b0)); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        imem_ready  = 1'b0;
        dmem_ready  = 1'b0;
        zero        = 1'b0;
        set_ir(7'b0000000, 3'b000, 1'b0);
        test_reset();
        test_add_nohs();
        test_rtype_wait();
        test_itype();
        test_load_wait();
        test_store();
        test_branch();
        test_jal();
        test_illegal();
        test_illegal_decode();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
